// File: rtl/activity_readout_pkg.sv
// Shared types and constants for the activity-counter readout path.
// Build macro ACTIVITY_READOUT_CHECKSUM_EN selects 14-byte frames with a trailing XOR byte.
package activity_readout_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int         FRAME_LEN_BASE = 13;
    localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

`ifdef ACTIVITY_READOUT_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN_BASE);
`else
    localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN_BASE - 1);
`endif

    // Frame index 1..12 maps onto snapshot bytes 0..11 (fsm, pcwrite, recovery; LSB first).
    function automatic logic [7:0] snap_byte(input logic [95:0] snap, input logic [3:0] idx);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 12; i++) begin
            if (idx == 4'(i + 1)) b = snap[8*i +: 8];
        end
        return b;
    endfunction

endpackage

// File: rtl/readout_period_timer.sv
// Free-running auto-trigger timer: one-cycle tick each PERIOD_CYCLES cycles, never when 0.
// Unaffected by ACTIVITY_READOUT_CHECKSUM_EN.
module readout_period_timer #(
    parameter int unsigned PERIOD_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    // A zero period still builds a one-state counter so the ports stay used; tick is masked.
    localparam int unsigned P_EFF = (PERIOD_CYCLES == 0) ? 1 : PERIOD_CYCLES;
    localparam int unsigned CW    = (P_EFF > 1) ? $clog2(P_EFF) : 1;

    logic [CW-1:0] count;
    logic          at_end;

    assign at_end = (count == CW'(P_EFF - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (at_end) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (PERIOD_CYCLES != 0) && at_end;

endmodule

// File: rtl/activity_readout.sv
// Snapshot the three activity counters on a trigger and stream them as a framed byte sequence.
// Define ACTIVITY_READOUT_CHECKSUM_EN to append an XOR checksum byte (14-byte frames).
//
// state | meaning
// IDLE  | waiting for snap_req or auto-tick; tx_valid low
// SEND  | presenting frame byte idx; idx advances on each handshake
module activity_readout
    import activity_readout_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 0,
    parameter logic [7:0]  FRAME_HEADER  = DEFAULT_HEADER
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fsm_transition_count,
    input  logic [31:0] pcwrite_toggle_count,
    input  logic [31:0] recovery_cycle_count,
    input  logic        snap_req,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_count,
    output logic [7:0]  drop_count
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  idx;
    logic [95:0] snap;
    logic        tick;
    logic        trigger;
    logic        handshake;
    logic        last_hs;

    readout_period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    // A coincident snap_req and tick is a single trigger, so it never counts as a drop.
    assign trigger   = snap_req | tick;
    assign handshake = (state == SEND) && tx_ready;
    assign last_hs   = handshake && (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = SEND;
            SEND:    if (last_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            snap        <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            if (state == IDLE && trigger) begin
                snap <= {recovery_cycle_count, pcwrite_toggle_count, fsm_transition_count};
                idx  <= '0;
            end else if (handshake && !last_hs) begin
                idx <= idx + 4'd1;
            end
            if (last_hs) begin
                frame_count <= frame_count + 16'd1;
            end
            if (state == SEND && trigger && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

`ifdef ACTIVITY_READOUT_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = '0;
        for (int i = 0; i < 12; i++) begin
            checksum = checksum ^ snap[8*i +: 8];
        end
    end
`endif

    assign busy     = (state == SEND);
    assign tx_valid = (state == SEND);

    // Outputs derive only from registered state/idx/snap, so they hold steady under backpressure.
    always_comb begin
        tx_data = '0;
        if (state == SEND) begin
            if (idx == 4'd0) begin
                tx_data = FRAME_HEADER;
`ifdef ACTIVITY_READOUT_CHECKSUM_EN
            end else if (idx == LAST_IDX) begin
                tx_data = checksum;
`endif
            end else begin
                tx_data = snap_byte(snap, idx);
            end
        end
    end

endmodule

// File: tb/tb_activity_readout.sv
// Directed bench for activity_readout: table-driven frames plus drop, saturation and auto-tick sequences.
// Honours ACTIVITY_READOUT_CHECKSUM_EN for frame length and checksum byte.
module tb_activity_readout;

`ifdef ACTIVITY_READOUT_CHECKSUM_EN
    localparam int LEN = 14;
`else
    localparam int LEN = 13;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fsm_c, pc_c, rec_c;
    logic        snap_req, tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid, busy;
    logic [15:0] frame_count;
    logic [7:0]  drop_count;

    logic        reset2;
    logic [7:0]  tx_data2;
    logic        tx_valid2, busy2;
    logic [15:0] frame_count2;
    logic [7:0]  drop_count2;

    always #5 clk = ~clk;

    activity_readout dut (
        .clk                 (clk),
        .reset               (reset),
        .fsm_transition_count(fsm_c),
        .pcwrite_toggle_count(pc_c),
        .recovery_cycle_count(rec_c),
        .snap_req            (snap_req),
        .tx_data             (tx_data),
        .tx_valid            (tx_valid),
        .tx_ready            (tx_ready),
        .busy                (busy),
        .frame_count         (frame_count),
        .drop_count          (drop_count)
    );

    activity_readout #(.PERIOD_CYCLES(20)) dut_auto (
        .clk                 (clk),
        .reset               (reset2),
        .fsm_transition_count(32'h0000_0003),
        .pcwrite_toggle_count(32'h0000_0005),
        .recovery_cycle_count(32'h0000_0001),
        .snap_req            (1'b0),
        .tx_data             (tx_data2),
        .tx_valid            (tx_valid2),
        .tx_ready            (1'b1),
        .busy                (busy2),
        .frame_count         (frame_count2),
        .drop_count          (drop_count2)
    );

    // exp holds frame bytes 0..13 with byte 0 in the top 8 bits.
    typedef struct packed {
        logic [31:0]  fsm;
        logic [31:0]  pc;
        logic [31:0]  rec;
        logic [3:0]   stall_idx;
        logic [3:0]   stall_len;
        logic [15:0]  drop_mask;
        logic [111:0] exp;
    } vec_t;

    vec_t tbl [4];
    int   passed = 0;
    int   total  = 0;
    int   exp_frames = 0;
    int   exp_drop   = 0;

    function automatic logic [7:0] eb(input logic [111:0] e, input int k);
        return e[111 - 8*k -: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    task automatic bump_drop(input int n);
        exp_drop = (exp_drop + n > 255) ? 255 : exp_drop + n;
    endtask

    // Called on a negedge in IDLE; returns on the negedge of the IDLE cycle after the frame.
    task automatic run_frame(input int v);
        int nb, stall, busy_cyc;
        fsm_c    = tbl[v].fsm;
        pc_c     = tbl[v].pc;
        rec_c    = tbl[v].rec;
        snap_req = 1'b1;
        tx_ready = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        nb = 0; stall = 0; busy_cyc = 0;
        while (nb < LEN) begin
            if (busy) busy_cyc++;
            if (nb == int'(tbl[v].stall_idx) && stall < int'(tbl[v].stall_len)) begin
                tx_ready = 1'b0;
                snap_req = 1'b0;
                check($sformatf("v%0d stall valid b%0d", v, nb), {31'b0, tx_valid}, 32'd1);
                check($sformatf("v%0d stall data b%0d", v, nb), {24'b0, tx_data}, {24'b0, eb(tbl[v].exp, nb)});
                stall++;
            end else begin
                tx_ready = 1'b1;
                snap_req = tbl[v].drop_mask[nb];
                if (tbl[v].drop_mask[nb]) bump_drop(1);
                check($sformatf("v%0d valid b%0d", v, nb), {31'b0, tx_valid}, 32'd1);
                check($sformatf("v%0d data b%0d", v, nb), {24'b0, tx_data}, {24'b0, eb(tbl[v].exp, nb)});
                nb++;
            end
            fsm_c = $urandom;
            pc_c  = $urandom;
            rec_c = $urandom;
            @(negedge clk);
        end
        snap_req = 1'b0;
        exp_frames++;
        check($sformatf("v%0d valid after frame", v), {31'b0, tx_valid}, 32'd0);
        check($sformatf("v%0d busy after frame", v), {31'b0, busy}, 32'd0);
        check($sformatf("v%0d busy cycles", v), busy_cyc, LEN + int'(tbl[v].stall_len));
        check($sformatf("v%0d frame_count", v), {16'b0, frame_count}, exp_frames);
        check($sformatf("v%0d drop_count", v), {24'b0, drop_count}, exp_drop);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_hdr, hdrs;
        logic prev_v, saw_v;

        tbl[0] = '{fsm: 32'h0000_0003, pc: 32'h0000_0005, rec: 32'h0000_0001,
                   stall_idx: 4'd15, stall_len: 4'd0, drop_mask: 16'h0000,
                   exp: {8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                         8'h01, 8'h00, 8'h00, 8'h00, 8'h07}};
        tbl[1] = tbl[0];
        tbl[1].stall_idx = 4'd6;
        tbl[1].stall_len = 4'd3;
        tbl[2] = '{fsm: 32'h1234_5678, pc: 32'hDEAD_BEEF, rec: 32'h00FF_00FF,
                   stall_idx: 4'd15, stall_len: 4'd0,
                   drop_mask: 16'h0088 | (16'h0001 << (LEN - 1)),
                   exp: {8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                         8'hFF, 8'h00, 8'hFF, 8'h00, 8'h2A}};
        tbl[3] = '{fsm: 32'hFFFF_FFFF, pc: 32'h0000_0000, rec: 32'h8000_0001,
                   stall_idx: 4'd0, stall_len: 4'd2, drop_mask: 16'h0000,
                   exp: {8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00,
                         8'h01, 8'h00, 8'h00, 8'h80, 8'h81}};

        reset = 1'b1; reset2 = 1'b1;
        snap_req = 1'b0; tx_ready = 1'b1;
        fsm_c = '0; pc_c = '0; rec_c = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        check("reset tx_valid", {31'b0, tx_valid}, 32'd0);
        check("reset tx_data", {24'b0, tx_data}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset frame_count", {16'b0, frame_count}, 32'd0);
        check("reset drop_count", {24'b0, drop_count}, 32'd0);
        @(negedge clk);
        check("idle stays idle", {31'b0, tx_valid}, 32'd0);

        for (int v = 0; v < 4; v++) run_frame(v);

        // Saturation: hold snap_req high under backpressure for 300 cycles.
        fsm_c = tbl[0].fsm; pc_c = tbl[0].pc; rec_c = tbl[0].rec;
        tx_ready = 1'b0;
        snap_req = 1'b1;
        repeat (100) @(negedge clk);
        bump_drop(99);
        check("drop_count mid", {24'b0, drop_count}, exp_drop);
        repeat (200) @(negedge clk);
        bump_drop(200);
        check("drop_count saturated", {24'b0, drop_count}, 32'd255);
        check("drop_count saturated model", exp_drop, 32'd255);
        snap_req = 1'b0;
        tx_ready = 1'b1;
        for (int k = 0; k < LEN; k++) begin
            check($sformatf("drain data b%0d", k), {24'b0, tx_data}, {24'b0, eb(tbl[0].exp, k)});
            @(negedge clk);
        end
        exp_frames++;
        check("drain done", {31'b0, tx_valid}, 32'd0);
        check("drain frame_count", {16'b0, frame_count}, exp_frames);
        check("drop_count held", {24'b0, drop_count}, 32'd255);

        // Auto-trigger instance: release reset, this negedge is cycle 0.
        reset2 = 1'b0;
        first_hdr = -1; hdrs = 0; prev_v = 1'b0;
        for (int c = 0; c < 114; c++) begin
            if (tx_valid2 && !prev_v && tx_data2 == 8'hA5) begin
                hdrs++;
                if (first_hdr < 0) first_hdr = c;
            end
            prev_v = tx_valid2;
            @(negedge clk);
        end
        check("auto first header cycle", first_hdr, 32'd20);
        check("auto header count", hdrs, 32'd5);
        check("auto frame_count", {16'b0, frame_count2}, 32'd5);
        check("auto drop_count", {24'b0, drop_count2}, 32'd0);
        repeat (13) @(negedge clk);
        check("auto idx7 valid", {31'b0, tx_valid2}, 32'd1);
        check("auto idx7 data", {24'b0, tx_data2}, {24'b0, eb(tbl[0].exp, 7)});
        reset2 = 1'b1;
        @(negedge clk);
        check("abort valid", {31'b0, tx_valid2}, 32'd0);
        check("abort busy", {31'b0, busy2}, 32'd0);
        // Aborted frame is not counted; frame_count shows its reset value.
        check("abort frame_count", {16'b0, frame_count2}, 32'd0);
        reset2 = 1'b0;
        saw_v = 1'b0;
        for (int c = 0; c < 20; c++) begin
            saw_v = saw_v | tx_valid2;
            @(negedge clk);
        end
        check("no resume after abort", {31'b0, saw_v}, 32'd0);
        check("restart header valid", {31'b0, tx_valid2}, 32'd1);
        check("restart header data", {24'b0, tx_data2}, 32'h0000_00A5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
